prog_loader: RTL and testbench

Writer side of the 64-byte program memory. It accepts a framed byte stream over a valid/ready handshake and issues one memory write per data byte. It validates the frame (address range, length, checksum) and holds the CPU in reset while a load is in progress. It sits between the host link and the memory write port, so the normal, software-interrupt, exception and hardware-interrupt regions can be loaded at run time.

---
 rtl/prog_loader_pkg.sv | 42 ++++
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared address/data types, loader state and error codes, memory map constants
package prog_loader_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] phys_addr;
    } addr_t;

    typedef struct packed {
        logic [DATA_W-1:0] raw_data;
    } data_t;

    localparam logic [ADDR_W-1:0] NORMAL = 6'd0;
    localparam logic [ADDR_W-1:0] SWINT  = 6'd16;
    localparam logic [ADDR_W-1:0] EXC    = 6'd32;
    localparam logic [ADDR_W-1:0] HWINT  = 6'd48;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BAD_ADDR = 2'd1,
        BAD_LEN  = 2'd2,
        BAD_CHK  = 2'd3
    } loader_err_t;

    // Widened so an oversized length byte cannot wrap back into range.
    function automatic logic len_ok(input logic [ADDR_W-1:0] base, input logic [7:0] len);
        return (len != 8'd0) && (({3'b000, base} + {1'b0, len}) <= 9'(MEM_DEPTH));
    endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing the program memory and holding the CPU while busy
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output addr_t       mem_addr,
    output data_t       mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        err_clr
);

    loader_state_t     r_state;
    loader_err_t       r_err_code;
    logic              r_in_ready;
    logic              r_mem_we;
    addr_t             r_mem_addr;
    data_t             r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_ptr;
    logic [6:0]        r_cnt;
    logic [7:0]        r_acc;
    logic [7:0]        w_acc_next;

    assign w_acc_next = r_acc + in_data;

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

    // in_ready is low only in DONE and ERR, so in_valid alone marks a transfer elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= NONE;
            r_base      <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    if (in_data[7:6] != 2'b00) begin
                        r_state    <= ERR;
                        r_err      <= 1'b1;
                        r_err_code <= BAD_ADDR;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_base  <= in_data[5:0];
                        r_acc   <= in_data;
                        r_busy  <= 1'b1;
                        r_state <= LEN;
                    end
                end
                LEN: if (in_valid) begin
                    if (!len_ok(r_base, in_data)) begin
                        r_state    <= ERR;
                        r_err      <= 1'b1;
                        r_err_code <= BAD_LEN;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_cnt   <= in_data[6:0];
                        r_acc   <= w_acc_next;
                        r_ptr   <= r_base;
                        r_state <= DATA;
                    end
                end
                DATA: if (in_valid) begin
                    r_mem_we              <= 1'b1;
                    r_mem_addr.phys_addr  <= r_ptr;
                    r_mem_wdata.raw_data  <= in_data;
                    r_ptr                 <= r_ptr + 1'b1;
                    r_cnt                 <= r_cnt - 1'b1;
                    r_acc                 <= w_acc_next;
                    r_state               <= (r_cnt == 7'd1) ? CHK : DATA;
                end
                CHK: if (in_valid) begin
                    r_acc      <= w_acc_next;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    if (w_acc_next == 8'd0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ERR;
                        r_err      <= 1'b1;
                        r_err_code <= BAD_CHK;
                    end
                end
                DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                ERR: if (err_clr) begin
                    r_err      <= 1'b0;
                    r_err_code <= NONE;
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames with a scoreboard of expected writes, done pulses and error codes
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    addr_t      mem_addr;
    data_t      mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int a;
        int d;
    } exp_t;

    exp_t q[$];
    logic prev_err = 1'b0;

    localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int a, input int d);
        q.push_back('{k, a, d});
    endtask

    task automatic observe(input int k, input int a, input int d);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected nothing", k, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.a != a || e.d != d) begin
                errors++;
                $display("FAIL event: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
                         k, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor: every write strobe, done pulse and error onset must match the next expected event.
    always @(negedge clk) begin
        if (mem_we) observe(K_WR, int'(mem_addr.phys_addr), int'(mem_wdata.raw_data));
        if (done) observe(K_DONE, 0, 0);
        if (err && !prev_err) observe(K_ERR, 0, int'(err_code));
        prev_err = err;
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 for byte %0h", b);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        #1 check(name, q.size(), 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_after_clr", int'(err), 0);
        check("code_after_clr", int'(err_code), 0);
        check("ready_after_clr", int'(in_ready), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_mem_we"}, int'(mem_we), 0);
        check({tag, "_mem_addr"}, int'(mem_addr.phys_addr), 0);
        check({tag, "_mem_wdata"}, int'(mem_wdata.raw_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_err_code"}, int'(err_code), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset");

        // Good frame, no stalls.
        push(K_WR, 'h00, 'hB7);
        push(K_WR, 'h01, 'h01);
        push(K_DONE, 0, 0);
        send(8'h00, 0);
        check("busy_after_addr", int'(busy), 1);
        send(8'h02, 0);
        send(8'hB7, 0);
        send(8'h01, 0);
        check("busy_during_data", int'(busy), 1);
        send(8'h46, 0);
        check("done_cycle_done", int'(done), 1);
        check("done_cycle_busy", int'(busy), 0);
        check("done_cycle_ready", int'(in_ready), 0);
        drain("good_frame_q");
        check("good_frame_err", int'(err), 0);

        // Region load with stalls between bytes.
        push(K_WR, 'h30, 'hFF);
        push(K_DONE, 0, 0);
        send(8'h30, 3);
        send(8'h01, 3);
        send(8'hFF, 3);
        send(8'hD0, 3);
        drain("region_q");

        // Overrun: base 3F + len 2 exceeds memory.
        push(K_ERR, 0, 2);
        send(8'h3F, 0);
        send(8'h02, 0);
        repeat (4) @(negedge clk);
        check("overrun_ready", int'(in_ready), 0);
        check("overrun_err", int'(err), 1);
        check("overrun_code", int'(err_code), 2);
        check("overrun_busy", int'(busy), 0);
        clear_err();
        push(K_WR, 'h00, 'h00);
        push(K_DONE, 0, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hFF, 0);
        drain("after_overrun_q");

        // Bad address, then zero length.
        push(K_ERR, 0, 1);
        send(8'h40, 0);
        check("badaddr_code", int'(err_code), 1);
        check("badaddr_busy", int'(busy), 0);
        drain("badaddr_q");
        clear_err();
        push(K_ERR, 0, 2);
        send(8'h05, 0);
        send(8'h00, 0);
        drain("zerolen_q");
        clear_err();

        // Bad checksum: the data byte is still written.
        push(K_WR, 'h00, 'hAA);
        push(K_ERR, 0, 3);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'h00, 0);
        drain("badchk_q");
        check("badchk_code", int'(err_code), 3);
        clear_err();

        // Reset in the middle of DATA.
        push(K_WR, 'h00, 'h11);
        push(K_WR, 'h01, 'h22);
        send(8'h00, 0);
        send(8'h04, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset("midreset");
        drain("midreset_q");

        // Full frame after reset, immediately followed by a back-to-back frame.
        push(K_WR, 'h10, 'h5A);
        push(K_WR, 'h11, 'hA5);
        push(K_DONE, 0, 0);
        push(K_WR, 'h20, 'h77);
        push(K_DONE, 0, 0);
        send(8'h10, 0);
        send(8'h02, 0);
        send(8'h5A, 0);
        send(8'hA5, 0);
        send(8'hEF, 0);
        send(8'h20, 0);
        send(8'h01, 0);
        send(8'h77, 0);
        send(8'h68, 0);
        drain("b2b_q");
        check("b2b_err", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
